// File: rtl/tmac_uni_pkg.sv
// Shared types and defaults for the temporal-unary MAC datapath.
package tmac_uni_pkg;

   localparam int unsigned MAC_TERMS = 16;
   localparam int unsigned UNI_IN_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      RUN,
      LOAD_WAIT,
      DONE
   } acc_state_t;

endpackage : tmac_uni_pkg

// File: rtl/tmac_acc_uni_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear; once at all-ones it stays there.
module sat_cnt #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] cnt_nxt_c
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_c = cnt_d;

endmodule : sat_cnt

// File: rtl/tmac_acc_uni.sv
// Receive end of the unipolar temporal product streams: counts ones per term window
// and presents the saturated sum of NUM_TERMS terms on a valid/ready interface.
module tmac_acc_uni
   import tmac_uni_pkg::*;
#(
   parameter int unsigned NUM_TERMS = MAC_TERMS,
   parameter int unsigned IN_W      = UNI_IN_W,
   parameter int unsigned ACC_W     = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iClr,
   input  logic             iLoad,
   input  logic             iStop,
   input  logic             iBit,
   output logic [ACC_W-1:0] oSum,
   output logic             oValid,
   input  logic             iReady,
   output logic             oBusy,
   output logic             oDrop
);

   localparam int unsigned TERM_W = $clog2(NUM_TERMS + 1);

   if ((IN_W == 0) || (ACC_W == 0) || (NUM_TERMS == 0)) begin : g_bad_cfg
      $error("tmac_acc_uni: IN_W, ACC_W and NUM_TERMS must be nonzero");
   end

   acc_state_t        state_q;
   acc_state_t        state_d;
   logic [TERM_W-1:0] term_q;
   logic [TERM_W-1:0] term_d;
   logic [ACC_W-1:0]  sum_q;
   logic [ACC_W-1:0]  sum_d;
   logic              valid_q;
   logic              valid_d;
   logic              busy_q;
   logic              busy_d;
   logic              drop_q;
   logic              drop_d;

   logic              acc_en_c;
   logic              acc_clr_c;
   logic [ACC_W-1:0]  acc_c;
   logic [ACC_W-1:0]  acc_nxt_c;

   sat_cnt #(
      .WIDTH (ACC_W)
   ) u_acc (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (acc_clr_c),
      .en_i      (acc_en_c),
      .cnt_o     (acc_c),
      .cnt_nxt_c (acc_nxt_c)
   );

   // Next-state, term counting and registered-output next values.
   always_comb begin
      state_d   = state_q;
      term_d    = term_q;
      acc_en_c  = 1'b0;
      drop_d    = 1'b0;
      acc_clr_c = 1'b0;
      sum_d     = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;

      if (iClr) begin
         state_d = IDLE;
         term_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               term_d = '0;
               if (iLoad) begin
                  state_d = SETTLE;
               end
            end
            SETTLE: begin
               state_d = RUN;
            end
            RUN: begin
               acc_en_c = ~iStop & iBit;
               // A load before stop truncates the term; it still counts as complete.
               if (iStop || iLoad) begin
                  term_d = term_q + TERM_W'(1);
                  if (term_d == TERM_W'(NUM_TERMS)) begin
                     state_d = DONE;
                     drop_d  = iLoad;
                  end else if (iLoad) begin
                     state_d = SETTLE;
                  end else begin
                     state_d = LOAD_WAIT;
                  end
               end
            end
            LOAD_WAIT: begin
               if (iLoad) begin
                  state_d = SETTLE;
               end
            end
            DONE: begin
               drop_d = iLoad;
               if (iReady) begin
                  state_d = IDLE;
                  term_d  = '0;
               end
            end
            default: begin
               state_d = IDLE;
               term_d  = '0;
            end
         endcase
      end

      acc_clr_c = (state_d == IDLE);
      valid_d   = (state_d == DONE);
      busy_d    = (state_d != IDLE);
      sum_d     = (state_d == DONE) ? acc_nxt_c : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         term_q  <= '0;
         sum_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         term_q  <= term_d;
         sum_q   <= sum_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         drop_q  <= drop_d;
      end
   end

   assign oSum   = sum_q;
   assign oValid = valid_q;
   assign oBusy  = busy_q;
   assign oDrop  = drop_q;

endmodule : tmac_acc_uni

// File: doc/tmac_acc_uni.md
Name: tmac_acc_uni

Overview:
Temporal-unary stream decoder and accumulator: the receive end of the tMUL_uni product stream. It counts '1' bits of each product stream over that stream's active window, delimited by the multiplier's load and stop signals. It sums NUM_TERMS consecutive product streams into one binary result and presents it with a valid/ready handshake. It sits after the 16 multiplier terms of the MAC16 non-scaled unipolar datapath.

Parameters:
NUM_TERMS, 16, number of product streams accumulated per result
IN_W, 8, multiplier operand width; max ones per stream = 2^IN_W-1
ACC_W, 12, accumulator/result width; default holds 16*255=4080
TERM_W, $clog2(NUM_TERMS+1), term counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
iClr  in  1  synchronous abort/clear; highest priority after reset
iLoad  in  1  same pulse as the multiplier's loadA; marks start of a term
iStop  in  1  multiplier stop; 0 = stream active
iBit  in  1  multiplier oC stream bit
oSum  out  ACC_W  accumulated result, valid when oValid=1
oValid  out  1  result available
iReady  in  1  consumer accepts result when oValid&iReady
oBusy  out  1  1 in any state other than IDLE
oDrop  out  1  one-cycle pulse: iLoad ignored in DONE

Behaviour:
- Reset: state=IDLE, acc=0, term count=0, oSum=0, oValid=0, oBusy=0, oDrop=0.
- Reset mid-operation aborts immediately; partial sum discarded.
- States: IDLE, SETTLE, RUN, LOAD_WAIT, DONE.
- IDLE: acc=0, term count=0. iLoad -> SETTLE.
- SETTLE: one cycle; no counting. The multiplier's stop is still 1 from its load. Always -> RUN.
- RUN:
  - Each cycle with iStop=0 and iBit=1, acc += 1, saturating at 2^ACC_W-1.
  - First cycle with iStop=1 ends the term; the bit in that cycle is not counted. Term count += 1.
  - If the new count equals NUM_TERMS -> DONE; else -> LOAD_WAIT.
  - A zero-length stream (operand A=0, iStop never falls) ends in the first RUN cycle and contributes 0.
- LOAD_WAIT: iLoad -> SETTLE. iStop/iBit are ignored.
- iLoad in RUN (before iStop=1): the current term is truncated and counted as complete. The bit in that cycle is counted if iStop=0. Next state:
  - SETTLE if the new count < NUM_TERMS;
  - DONE if it reaches NUM_TERMS; that load is dropped and oDrop pulses.
- DONE:
  - oValid=1; oSum=acc, held stable while iReady=0.
  - oValid&iReady -> IDLE next cycle; acc cleared.
  - iLoad in DONE is ignored and pulses oDrop the next cycle.
  - If iLoad and iReady coincide, the load is still dropped.
- Latency: oValid rises the cycle after the final term's end cycle.
- oSum is registered. It is 0 outside DONE.
- iClr: next state IDLE, all counters cleared, oValid=0, no oDrop. Takes priority over iLoad and iReady.
- Width rule: the accumulator is ACC_W bits with saturate, never wrap. Sticky saturation persists until IDLE.

Decomposition:
- Shared package (tmac_uni_pkg):
  - state enum acc_state_t {IDLE, SETTLE, RUN, LOAD_WAIT, DONE};
  - default constants MAC_TERMS=16, UNI_IN_W=8.
- One natural sub-module: sat_cnt (saturating up-counter with enable and sync clear, param WIDTH), used for the accumulator.
- The term counter stays inline.

Test Plan:
- 16 terms, each: iLoad pulse, one idle cycle, iStop=0 for 8 cycles with iBit=1, then iStop=1 -> oValid one cycle after the 16th end, oSum=128, oBusy=1 throughout.
- 16 terms alternating iStop-low length 10 with iBit=1010101010 and zero-length (iStop held 1) -> oSum=8*5=40; zero-length terms complete in one RUN cycle.
- After DONE, hold iReady=0 for 5 cycles and pulse iLoad at cycle 2 -> oSum stable, oValid=1, oDrop high exactly 1 cycle; iReady=1 -> IDLE, oSum=0 next cycle.
- iLoad asserted after 3 counted ones in term 1 of a 16-term run -> term 1 contributes 3, term count advances to 1, state SETTLE; final result equals 3 + remaining terms' ones.
- Override ACC_W=8, 16 terms of 255 ones each -> oSum=255 (saturated, no wrap); rst_n low mid-RUN of term 7 -> all outputs 0 immediately; a fresh run then yields the correct sum.
- iClr asserted in RUN of term 4 with iLoad the same cycle -> IDLE next cycle, oValid=0, oDrop=0, acc=0; a subsequent 16-term run of 1 one each -> oSum=16.
